param_sp_ram: RTL and testbench



---
 rtl/param_sp_ram_pkg.sv | 14 +
 rtl/param_sp_ram_clr_seq.sv | 80 ++++++++
 rtl/param_sp_ram.sv | 131 +++++++++++++
 tb/tb_param_sp_ram.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_sp_ram_pkg.sv
// param_sp_ram_pkg: shared types and constants for the param_sp_ram storage
// primitive.
//   ram_state_e : two-state sequencer encoding (INIT clears the array, IDLE serves accesses)
//   BYTE_W      : width of one byte lane controlled by a single byte enable
package param_sp_ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } ram_state_e;

endpackage

// File: rtl/param_sp_ram_clr_seq.sv
// param_sp_ram_clr_seq: clear sequencer for param_sp_ram. After reset, or on a
// clr_i pulse while idle, it walks every word address once, one per cycle,
// asserting a write enable so the array can load the clear value. It then
// reports the array ready for normal accesses.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset; restarts the clear at address 0
//   clr_i        single-cycle request to clear the whole array (ignored while clearing)
//   clr_we_o     clear write enable for the array
//   clr_addr_o   word address being cleared this cycle
//   ready_o      1 when the array accepts accesses (state IDLE)
//   init_busy_o  1 while the clear walk runs (state INIT)
module param_sp_ram_clr_seq
    import param_sp_ram_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              ready_o,
    output logic              init_busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    // One bit wider than the address so the terminal count is an explicit
    // compare rather than relying on the pointer wrapping to zero.
    localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

    ram_state_e      state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                // clr_i is deliberately not looked at here: a clear in
                // progress runs to completion without restarting.
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            IDLE: begin
                if (clr_i) begin
                    state_d = INIT;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                ptr_d   = '0;
            end
        endcase
    end

    assign clr_we_o    = (state_q == INIT);
    assign clr_addr_o  = ptr_q[ADDR_W-1:0];
    assign ready_o     = (state_q == IDLE);
    assign init_busy_o = (state_q == INIT);

endmodule

// File: rtl/param_sp_ram.sv
// param_sp_ram: parametrised single-port synchronous RAM with per-byte write
// enables, a read-valid strobe and a hardware clear sequencer. The array is
// cleared one word per cycle after reset or on request; accesses are accepted
// only while ready_o is high.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_i        access request, accepted only when ready_o=1 and clr_i=0
//   we_i         1=write, 0=read
//   be_i         byte enables for writes (bit k covers data[8k+7:8k])
//   addr_i       word address
//   wr_data_i    write data
//   clr_i        single-cycle pulse starting a full-array clear
//   ready_o      1 when accesses are accepted
//   rd_data_o    read data, held until the next read completes
//   rd_valid_o   one-cycle strobe marking rd_data_o valid
//   init_busy_o  1 while the clear sequencer runs
//
// Build option:
//   PARAM_SP_RAM_OUT_REG_EN  when defined, an extra output register follows
//                            the array; read latency becomes 2 cycles.
module param_sp_ram
    import param_sp_ram_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 7,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [DATA_W/BYTE_W-1:0] be_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     clr_i,
    output logic                     ready_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_valid_o,
    output logic                     init_busy_o
);

    localparam int BE_W  = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;
    logic              acc_ok;
    logic              wr_en;
    logic              rd_en;

    logic [DATA_W-1:0] mem_q [DEPTH];

    param_sp_ram_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .ready_o     (ready),
        .init_busy_o (init_busy_o)
    );

    assign ready_o = ready;

    // A clear request in the same cycle as an access wins; the access is
    // dropped. Reset likewise drops anything presented alongside it.
    assign acc_ok = req_i & ready & ~clr_i & ~rst_i;
    assign wr_en  = acc_ok & we_i;
    assign rd_en  = acc_ok & ~we_i;

    // Array: clear writes and byte-lane writes never overlap because the
    // sequencer and ready are mutually exclusive.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_addr] <= CLR_VAL;
        end else if (wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_i[k]) begin
                    mem_q[addr_i][k*BYTE_W +: BYTE_W] <= wr_data_i[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read stage 1: array output register
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem_q[addr_i];
            end
        end
    end

`ifdef PARAM_SP_RAM_OUT_REG_EN
    // Read stage 2: optional output register, advances only on valid data so
    // rd_data_o still holds its last value between reads.
    logic [DATA_W-1:0] rd_data_out_q;
    logic              rd_valid_out_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_out_q <= 1'b0;
            rd_data_out_q  <= '0;
        end else begin
            rd_valid_out_q <= rd_valid_q;
            if (rd_valid_q) begin
                rd_data_out_q <= rd_data_q;
            end
        end
    end

    assign rd_data_o  = rd_data_out_q;
    assign rd_valid_o = rd_valid_out_q;
`else
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_param_sp_ram.sv
module tb_param_sp_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef PARAM_SP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr;
    logic              ready_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              init_busy_o;

    param_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .be_i        (be),
        .addr_i      (addr),
        .wr_data_i   (wr_data),
        .clr_i       (clr),
        .ready_o     (ready_o),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .init_busy_o (init_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Advance one clock; the bench always sits at a falling edge. Any read
    // strobe seen here is matched against the oldest expected read.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (rd_valid_o !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_spurious: rd_valid_o=%b at cycle %0d, required 0", rd_valid_o, cyc);
            end else begin
                e = sb.pop_front();
                if (rd_data_o !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d",
                             rd_data_o, cyc, e.data, e.due);
                end
            end
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [BE_W-1:0] b);
        req = 1'b1; we = 1'b1; addr = a; wr_data = d; be = b;
        cycle();
        req = 1'b0; we = 1'b0; be = '0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d);
        req = 1'b1; we = 1'b0; addr = a;
        sb.push_back('{data: exp_d, due: cyc + LAT});
        cycle();
        req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            cycle();
        end
    endtask

    // Counts consecutive busy cycles starting with the current one.
    task automatic count_busy(output int n, output int rdy_bad);
        n = 0;
        rdy_bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (init_busy_o !== 1'b1) break;
            n++;
            if (ready_o !== 1'b0) rdy_bad++;
            cycle();
        end
    endtask

    task automatic test_reset();
        int n, rb;
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready_o); end
        checks++;
        if (init_busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", init_busy_o); end
        checks++;
        if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", rd_valid_o); end
        checks++;
        if (rd_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", rd_data_o); end
        rst = 1'b0;
        count_busy(n, rb);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL init_len: got %0d cycles, required %0d", n, DEPTH); end
        checks++;
        if (rb != 0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL init_ready: ready high %0d busy cycles, ready_o=%b after, required 0 and 1", rb, ready_o);
        end
        do_read(7'd0, '0);
        do_read(7'd64, '0);
        do_read(7'd127, '0);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL reset_reads_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_byte_en();
        do_write(7'd5, 32'hAABBCCDD, 4'hF);
        do_write(7'd5, 32'h11223344, 4'h5);
        do_read(7'd5, 32'hAA22CC44);
        do_write(7'd5, 32'hFFFFFFFF, 4'h0);
        do_read(7'd5, 32'hAA22CC44);
        do_write(7'd6, 32'h0000BEEF, 4'h3);
        do_read(7'd6, 32'h0000BEEF);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL byte_en_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), DATA_W'(i), 4'hF);
        for (int i = 0; i < 8; i++) do_read(ADDR_W'(i), DATA_W'(i));
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_clear_drop();
        int n, rb;
        do_write(7'd3, 32'h0000005A, 4'hF);
        do_read(7'd3, 32'h0000005A);
        // clear together with a write that must be dropped
        clr = 1'b1; req = 1'b1; we = 1'b1; addr = 7'd9; wr_data = 32'hFF; be = 4'hF;
        cycle();
        clr = 1'b0; req = 1'b0; we = 1'b0; be = '0;
        count_busy(n, rb);
        checks++;
        if (n != DEPTH || rb != 0) begin
            errors++;
            $display("FAIL clear_len: got %0d busy cycles (%0d ready), required %0d (0)", n, rb, DEPTH);
        end
        do_read(7'd3, '0);
        do_read(7'd9, '0);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL clear_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_busy_request();
        int n;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (init_busy_o !== 1'b1) break;
            n++;
            if (n == 10) clr = 1'b1;
            if (n == 11) begin clr = 1'b0; req = 1'b1; we = 1'b0; addr = 7'd2; end
            if (n == 12) begin we = 1'b1; wr_data = 32'h00001234; be = 4'hF; end
            if (n == 13) begin req = 1'b0; we = 1'b0; be = '0; end
            cycle();
        end
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL busy_len: got %0d cycles, required %0d", n, DEPTH); end
        do_read(7'd2, '0);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL busy_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid_init();
        int n, rb;
        do_write(7'd7, 32'hCAFEF00D, 4'hF);
        do_read(7'd7, 32'hCAFEF00D);
        drain();
        checks++;
        if (rd_data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_data: got %h, required cafef00d", rd_data_o); end
        // read presented with reset: must never complete
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 7'd7;
        cycle();
        rst = 1'b0; req = 1'b0;
        checks++;
        if (rd_data_o !== '0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: rd_data_o=%h ready_o=%b, required 0 and 0", rd_data_o, ready_o);
        end
        n = 1;
        for (int i = 0; i < 200; i++) begin
            if (n >= 41) break;
            cycle();
            n++;
        end
        // current cycle clears ptr=40
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_busy(n, rb);
        checks++;
        if (n != DEPTH || rb != 0) begin
            errors++;
            $display("FAIL midrst_len: got %0d busy cycles (%0d ready), required %0d (0)", n, rb, DEPTH);
        end
        do_read(7'd7, '0);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL midrst_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wr_data = '0; clr = 1'b0;
        test_reset();
        test_byte_en();
        test_back_to_back();
        test_clear_drop();
        test_busy_request();
        test_reset_mid_init();
        for (int i = 0; i < 4; i++) cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
